// File: rtl/deser_pkg.sv
// Shared definitions for the left-shift deserializer: FSM state encoding and
// the bit_count width helper.
package deser_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PARITY  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // bit_count must be able to hold the value SIZE, not just SIZE-1.
  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/left_shift_deserializer_ctrl_if.sv
// Serial-in / word-out handshake bundle for left_shift_deserializer_ctrl.
// master = producer/consumer side, slave = deserializer side.
interface left_shift_deserializer_ctrl_if #(
  parameter int SIZE = 8
);
  localparam int CW = deser_pkg::cnt_w(SIZE);

  logic            flush;
  logic            bit_in;
  logic            bit_valid;
  logic            bit_ready;
  logic [SIZE-1:0] word_out;
  logic            word_valid;
  logic            word_ready;
  logic [CW-1:0]   bit_count;
  logic            parity_error;

  modport master (
    output flush, bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, bit_count, parity_error
  );

  modport slave (
    input  flush, bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, bit_count, parity_error
  );
endinterface

// File: rtl/left_shift_register_base.sv
// Generic left-shift register: new bit enters at bit 0, MSB-first input ends
// up in out[SIZE-1] after SIZE shifts.
module left_shift_register_base #(
  parameter int SIZE = 8
) (
  input  logic            in,
  input  logic            clk,
  input  logic            enable,
  input  logic            reset,
  output logic [SIZE-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset)       out <= '0;
    else if (enable) out <= {out[SIZE-2:0], in};
  end

endmodule

// File: rtl/left_shift_deserializer_ctrl.sv
// Serial-to-parallel deserializer with COLLECT/PARITY/HOLD control.
// Define DESER_PARITY_EN to compile in even-parity checking of a trailing bit.
module left_shift_deserializer_ctrl
  import deser_pkg::*;
#(
  parameter int SIZE = 8
) (
  input logic                     clk,
  input logic                     reset,
  left_shift_deserializer_ctrl_if.slave bus
);

  localparam int CW = cnt_w(SIZE);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_count;
  logic [SIZE-1:0] w_word;
  logic            w_accept;
  logic            w_data_acc;
  logic            w_clr;
  logic            w_last;

  assign w_clr      = reset | bus.flush;
  assign w_accept   = bus.bit_valid & bus.bit_ready;
  assign w_data_acc = w_accept & (r_state == ST_COLLECT) & ~w_clr;
  assign w_last     = (r_count == CW'(SIZE - 1));

  assign bus.bit_ready  = (r_state != ST_HOLD);
  assign bus.word_valid = (r_state == ST_HOLD);
  assign bus.word_out   = w_word;
  assign bus.bit_count  = r_count;

  left_shift_register_base #(.SIZE(SIZE)) u_sreg (
    .in     (bus.bit_in),
    .clk    (clk),
    .enable (w_data_acc),
    .reset  (w_clr),
    .out    (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_state <= ST_COLLECT;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            r_count <= r_count + CW'(1);
`ifdef DESER_PARITY_EN
            if (w_last) r_state <= ST_PARITY;
`else
            if (w_last) r_state <= ST_HOLD;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        ST_PARITY: if (w_accept) r_state <= ST_HOLD;
`endif
        ST_HOLD: begin
          if (bus.word_ready) begin
            r_count <= '0;
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

`ifdef DESER_PARITY_EN
  logic r_perr;

  // Flush leaves the flag alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      r_perr <= 1'b0;
    else if (!bus.flush && r_state == ST_PARITY && w_accept)
      r_perr <= (^w_word) ^ bus.bit_in;
  end

  assign bus.parity_error = r_perr;
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_left_shift_deserializer_ctrl.sv
// Directed bench for left_shift_deserializer_ctrl (SIZE=8); the parity
// scenario is selected when DESER_PARITY_EN is defined.
module tb_left_shift_deserializer_ctrl;

  typedef struct {
    logic       rst, fl, bin, bv, wr;
    logic       e_br, e_wv;
    logic [7:0] e_wo;
    logic [3:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  left_shift_deserializer_ctrl_if #(.SIZE(8)) bus();

  left_shift_deserializer_ctrl #(.SIZE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(logic rst, logic fl, logic bin, logic bv, logic wr,
                              logic br, logic wv, logic [7:0] wo, logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.bin = bin; v.bv = bv; v.wr = wr;
    v.e_br = br; v.e_wv = wv; v.e_wo = wo; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_all(input string nm, input logic br, input logic wv,
                           input logic [7:0] wo, input logic [3:0] cnt);
    chk({nm, ".bit_ready"},  32'(bus.bit_ready),  32'(br));
    chk({nm, ".word_valid"}, 32'(bus.word_valid), 32'(wv));
    chk({nm, ".word_out"},   32'(bus.word_out),   32'(wo));
    chk({nm, ".bit_count"},  32'(bus.bit_count),  32'(cnt));
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic fl, input logic bin,
                      input logic bv, input logic wr);
    reset = rst; bus.flush = fl; bus.bit_in = bin; bus.bit_valid = bv; bus.word_ready = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic wr);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, b[i], 1'b1, wr);
  endtask

  initial begin
    reset = 1'b1; bus.flush = 1'b0; bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0; bus.word_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("reset", 1'b1, 1'b0, 8'h00, 4'd0);
    chk("reset.parity_error", 32'(bus.parity_error), 32'd0);

`ifdef DESER_PARITY_EN
    send_byte(8'h5A, 1'b1);
    check_all("par_data_done", 1'b1, 1'b0, 8'h5A, 4'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("par0_hold", 1'b0, 1'b1, 8'h5A, 4'd8);
    chk("par0.parity_error", 32'(bus.parity_error), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("par0_handshake", 1'b1, 1'b0, 8'h5A, 4'd0);
    send_byte(8'h5A, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("par1_hold", 1'b0, 1'b1, 8'h5A, 4'd8);
    chk("par1.parity_error", 32'(bus.parity_error), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("par_flush_hold", 1'b1, 1'b0, 8'h00, 4'd0);
`else
    // Word 8'hB2 streamed with word_ready high, then flush after 3 bits and 8'hFF.
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h01,4'd1));
    tbl.push_back(mk(0,0,0,1,1, 1,0,8'h02,4'd2));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h05,4'd3));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h0B,4'd4));
    tbl.push_back(mk(0,0,0,1,1, 1,0,8'h16,4'd5));
    tbl.push_back(mk(0,0,0,1,1, 1,0,8'h2C,4'd6));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h59,4'd7));
    tbl.push_back(mk(0,0,0,1,1, 0,1,8'hB2,4'd8));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'hB2,4'd0));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h65,4'd1));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'hCB,4'd2));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h97,4'd3));
    tbl.push_back(mk(0,1,1,1,1, 1,0,8'h00,4'd0));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h01,4'd1));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h03,4'd2));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h07,4'd3));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h0F,4'd4));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h1F,4'd5));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h3F,4'd6));
    tbl.push_back(mk(0,0,1,1,1, 1,0,8'h7F,4'd7));
    tbl.push_back(mk(0,0,1,1,1, 0,1,8'hFF,4'd8));
    tbl.push_back(mk(0,0,0,0,1, 1,0,8'hFF,4'd0));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].bin, tbl[i].bv, tbl[i].wr);
      check_all($sformatf("vec%0d", i), tbl[i].e_br, tbl[i].e_wv, tbl[i].e_wo, tbl[i].e_cnt);
    end

    // Backpressure: word held stable while word_ready stays low.
    send_byte(8'hB2, 1'b0);
    check_all("bp_enter", 1'b0, 1'b1, 8'hB2, 4'd8);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_all($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 8'hB2, 4'd8);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_all("bp_release", 1'b1, 1'b0, 8'hB2, 4'd0);

    // bit_valid toggling: 8'h5A over 15 cycles, one bit per two cycles.
    for (int i = 0; i < 15; i++) begin
      logic [7:0] d;
      d = 8'h5A;
      step(1'b0, 1'b0, (i % 2 == 0) ? d[7 - i/2] : 1'b1, (i % 2 == 0), 1'b0);
      if (i < 14) chk($sformatf("tog%0d.bit_count", i), 32'(bus.bit_count), 32'(i/2 + 1));
    end
    check_all("tog_done", 1'b0, 1'b1, 8'h5A, 4'd8);

    // Flush in HOLD drops the word without a handshake.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("flush_hold", 1'b1, 1'b0, 8'h00, 4'd0);

    // Reset in HOLD.
    send_byte(8'h3C, 1'b0);
    check_all("rst_pre", 1'b0, 1'b1, 8'h3C, 4'd8);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("rst_hold", 1'b1, 1'b0, 8'h00, 4'd0);
    chk("rst_hold.parity_error", 32'(bus.parity_error), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
